// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for irq_controller: FSM states, register map, STATUS layout.
package irq_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned MISS_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PEND = 2'd0;
  localparam logic [ADDR_W-1:0] MASK = 2'd1;
  localparam logic [ADDR_W-1:0] STAT = 2'd2;
  localparam logic [ADDR_W-1:0] EOI  = 2'd3;

  localparam int unsigned STAT_STATE_LSB = 8;
  localparam int unsigned STAT_IRQ_BIT   = 7;
  localparam int unsigned STAT_ID_LSB    = 0;

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side register bus and interrupt request lines of irq_controller.
interface irq_controller_if
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned ID_W = 3
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              irq_out;
  logic [ID_W-1:0]   irq_id;

  modport master (output addr, we, din, input dout, irq_out, irq_id);
  modport slave  (input addr, we, din, output dout, irq_out, irq_id);
endinterface

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 3
) (
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id_c,
  output logic             valid_c
);

  // Scan high to low so the lowest set index is the last to assign.
  always_comb begin
    id_c    = '0;
    valid_c = 1'b0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        id_c    = ID_W'(i);
        valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Pending/mask interrupt controller with fixed priority and EOI handshake.
// Optional per-source missed-pulse counters under IRQ_CTRL_MISS_COUNT_EN.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 3
) (
  input  logic                 clk_cpu,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     src_irq,
  irq_controller_if.slave      bus
);

  localparam int unsigned N_RD = (N_SRC < 4) ? N_SRC : 4;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic               irq_out_q, irq_out_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  logic               wr_pend, wr_mask, wr_eoi, eoi_hit;
  logic [N_SRC-1:0]   clr, eligible, act_oh;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [DATA_W-1:0]  stat_c, rd_c;
  logic               din_unused;

  assign wr_pend    = bus.we && (bus.addr == PEND);
  assign wr_mask    = bus.we && (bus.addr == MASK);
  assign wr_eoi     = bus.we && (bus.addr == EOI);
  assign din_unused = ^bus.din;

  // Register writes and clears; a new pulse always survives a same-cycle clear.
  always_comb begin
    act_oh  = N_SRC'(1) << active_id_q;
    eoi_hit = wr_eoi && (state_q == ACTIVE) && (bus.din[ID_W-1:0] == active_id_q);
    mask_d  = wr_mask ? bus.din[N_SRC-1:0] : mask_q;
    clr     = '0;
    if (wr_pend) clr = clr | bus.din[N_SRC-1:0];
    if (eoi_hit) clr = clr | act_oh;
    pending_d = (pending_q & ~clr) | src_irq;
    // Arbitrate on registered pending so new pulses take two cycles to reach irq_out.
    eligible  = pending_q & ~clr & mask_d;
  end

  irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
    .req     (eligible),
    .id_c    (win_id),
    .valid_c (win_vld)
  );

  // GAP arbitrates like IDLE but its own cycle keeps irq_out low, giving the CPU a fresh edge.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    unique case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (win_vld) begin
          state_d     = ACTIVE;
          active_id_d = win_id;
        end
      end
      ACTIVE: begin
        if (eoi_hit)                             state_d = GAP;
        else if (!(|(pending_d & mask_d & act_oh))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    irq_out_d = (state_d == ACTIVE);
    irq_id_d  = irq_out_d ? active_id_d : '0;
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      active_id_q <= '0;
      irq_out_q   <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      active_id_q <= active_id_d;
      irq_out_q   <= irq_out_d;
      irq_id_q    <= irq_id_d;
    end
  end

`ifdef IRQ_CTRL_MISS_COUNT_EN
  logic [MISS_W-1:0] miss_q [N_SRC];
  logic [MISS_W-1:0] miss_d [N_SRC];

  // Any EOI write clears all counters; a same-cycle miss still counts.
  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) begin
      miss_d[i] = wr_eoi ? '0 : miss_q[i];
      if (src_irq[i] && pending_q[i] && (miss_d[i] != {MISS_W{1'b1}})) begin
        miss_d[i] = miss_d[i] + MISS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SRC); i++) miss_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_SRC); i++) miss_q[i] <= miss_d[i];
    end
  end
`endif

  always_comb begin
    stat_c = '0;
    stat_c[STAT_STATE_LSB +: 2]       = state_q;
    stat_c[STAT_IRQ_BIT]              = irq_out_q;
    stat_c[STAT_ID_LSB +: ID_W]       = active_id_q;
  end

  always_comb begin
    rd_c = '0;
    case (bus.addr)
      PEND: rd_c[N_SRC-1:0] = pending_q;
      MASK: rd_c[N_SRC-1:0] = mask_q;
      STAT: rd_c = stat_c;
      EOI: begin
`ifdef IRQ_CTRL_MISS_COUNT_EN
        for (int i = 0; i < int'(N_RD); i++) rd_c[i*MISS_W +: MISS_W] = miss_q[i];
`else
        rd_c = '0;
`endif
      end
    endcase
  end

  assign bus.dout    = rd_c;
  assign bus.irq_out = irq_out_q;
  assign bus.irq_id  = irq_id_q;

endmodule
